// File: rtl/drlp_mem_bridge_if.sv
// drlp_mem_bridge_if: drlp DMA ports plus the single-port memory bus
// slave  : the bridge (takes DMA requests, drives the memory request)
// master : the environment (drlp plus memory model)
interface drlp_mem_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  dma_rd_en;
  logic [ADDR_WIDTH-1:0] dma_rd_addr;
  logic [DATA_WIDTH-1:0] dma_rd_data;
  logic                  dma_rd_ready;
  logic                  dma_wr_en;
  logic [ADDR_WIDTH-1:0] dma_wr_addr;
  logic [DATA_WIDTH-1:0] dma_wr_data;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport slave (
    input  dma_rd_en, dma_rd_addr, dma_wr_en, dma_wr_addr, dma_wr_data,
           mem_gnt, mem_rvalid, mem_rdata,
    output dma_rd_data, dma_rd_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output dma_rd_en, dma_rd_addr, dma_wr_en, dma_wr_addr, dma_wr_data,
           mem_gnt, mem_rvalid, mem_rdata,
    input  dma_rd_data, dma_rd_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/drlp_mem_bridge.sv
// drlp_mem_bridge: arbitrates drlp DMA reads and FIFO-buffered writes onto one memory port
// clk, rst_n  : clock, asynchronous active-low reset
// bus         : DMA read/write ports and memory req/gnt/rvalid bus (slave modport)
// wfifo_level : write FIFO occupancy
// idle        : nothing pending, outstanding or buffered
// err_rd_ovf  : sticky, a read request was lost
// err_wr_ovf  : sticky, a write was dropped on a full FIFO
module drlp_mem_bridge #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WFIFO_DEPTH = 8,
  parameter int WFIFO_AW    = 3,
  parameter int HIGH_WATER  = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  drlp_mem_bridge_if.slave    bus,
  output logic [WFIFO_AW:0]   wfifo_level,
  output logic                idle,
  output logic                err_rd_ovf,
  output logic                err_wr_ovf
);
  localparam logic [WFIFO_AW:0] HW   = (WFIFO_AW+1)'(HIGH_WATER);
  localparam logic [WFIFO_AW:0] FULL = (WFIFO_AW+1)'(WFIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;
  state_t                             state;
  logic                               pend_v;
  logic [ADDR_WIDTH-1:0]              pend_addr;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   fifo_mem [WFIFO_DEPTH];
  logic [WFIFO_AW-1:0]                wptr, rptr;
  logic [WFIFO_AW:0]                  count;
  logic                               take_rd, take_wr, rd_acc, push, pop;
  assign take_rd     = state == IDLE && pend_v && count < HW;
  assign take_wr     = state == IDLE && !take_rd && count != '0;
  // a slot being handed to the FSM this cycle can be refilled in the same cycle
  assign rd_acc      = bus.dma_rd_en && (!pend_v || take_rd);
  assign pop         = state == WR_REQ && bus.mem_gnt;
  assign push        = bus.dma_wr_en && (count != FULL || pop);
  assign wfifo_level = count;
  assign idle        = state == IDLE && !pend_v && count == '0;
  always_ff @(posedge clk)
    if (push) fifo_mem[wptr] <= {bus.dma_wr_addr, bus.dma_wr_data};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v     <= 1'b0;
      pend_addr  <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      err_rd_ovf <= 1'b0;
      err_wr_ovf <= 1'b0;
    end else begin
      pend_v <= rd_acc || (pend_v && !take_rd);
      if (rd_acc) pend_addr <= bus.dma_rd_addr;
      if (push) wptr <= wptr + WFIFO_AW'(1);
      if (pop) rptr <= rptr + WFIFO_AW'(1);
      count <= count + (WFIFO_AW+1)'(push) - (WFIFO_AW+1)'(pop);
      if (bus.dma_rd_en && !rd_acc) err_rd_ovf <= 1'b1;
      if (bus.dma_wr_en && !push) err_wr_ovf <= 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      bus.mem_req      <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.dma_rd_data  <= '0;
      bus.dma_rd_ready <= 1'b0;
    end else begin
      bus.dma_rd_ready <= 1'b0;
      case (state)
        IDLE:
          if (take_rd) begin
            state        <= RD_REQ;
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= pend_addr;
          end else if (take_wr) begin
            state                          <= WR_REQ;
            bus.mem_req                    <= 1'b1;
            bus.mem_we                     <= 1'b1;
            {bus.mem_addr, bus.mem_wdata}  <= fifo_mem[rptr];
          end
        RD_REQ:
          if (bus.mem_gnt) begin
            state       <= RD_WAIT;
            bus.mem_req <= 1'b0;
          end
        RD_WAIT:
          if (bus.mem_rvalid) begin
            state            <= IDLE;
            bus.dma_rd_data  <= bus.mem_rdata;
            bus.dma_rd_ready <= 1'b1;
          end
        WR_REQ:
          if (bus.mem_gnt) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_drlp_mem_bridge.sv
// tb_drlp_mem_bridge: transaction-level model check plus directed scenarios for drlp_mem_bridge
module tb_drlp_mem_bridge;
  localparam int AW = 32, DW = 32, DEPTH = 8, HWM = 6;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] level;
  logic idle, err_rd, err_wr;
  int total = 0, bad = 0;
  drlp_mem_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  drlp_mem_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WFIFO_DEPTH(DEPTH), .WFIFO_AW(3), .HIGH_WATER(HWM)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .wfifo_level(level), .idle(idle),
    .err_rd_ovf(err_rd), .err_wr_ovf(err_wr)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: a queue of buffered writes, a queue holding the pending read,
  // and one in-flight memory transaction
  logic [AW+DW-1:0] m_wq[$];
  logic [AW-1:0]    m_pend[$];
  bit               m_act, m_we, m_gr, m_rdy, m_erd, m_ewr;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_data, m_rdata;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wq.delete(); m_pend.delete();
      m_act = 0; m_we = 0; m_gr = 0; m_rdy = 0; m_erd = 0; m_ewr = 0;
      m_addr = '0; m_data = '0; m_rdata = '0;
    end else begin
      bit gnt_now, pop_w, rd_done, start_rd, start_wr, pend_empty;
      int wq_n;
      wq_n       = m_wq.size();
      pend_empty = m_pend.size() == 0;
      gnt_now    = m_act && !m_gr && bus.mem_gnt;
      pop_w      = gnt_now && m_we;
      rd_done    = m_act && !m_we && m_gr && bus.mem_rvalid;
      start_rd   = !m_act && !pend_empty && wq_n < HWM;
      start_wr   = !m_act && !start_rd && wq_n != 0;
      m_rdy = rd_done;
      if (rd_done) begin m_rdata = bus.mem_rdata; m_act = 0; end
      if (gnt_now) begin
        if (m_we) begin m_act = 0; void'(m_wq.pop_front()); end
        else m_gr = 1;
      end
      if (start_rd) begin m_act = 1; m_we = 0; m_gr = 0; m_addr = m_pend.pop_front(); end
      else if (start_wr) begin m_act = 1; m_we = 1; m_gr = 0; {m_addr, m_data} = m_wq[0]; end
      if (bus.dma_rd_en) begin
        if (pend_empty || start_rd) m_pend.push_back(bus.dma_rd_addr);
        else m_erd = 1;
      end
      if (bus.dma_wr_en) begin
        if (wq_n < DEPTH || pop_w) m_wq.push_back({bus.dma_wr_addr, bus.dma_wr_data});
        else m_ewr = 1;
      end
    end
  end
  logic          log_we[$];
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  int rdy_cnt = 0, peak = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("mem_req", bus.mem_req, m_act && !m_gr);
      if (bus.mem_req) begin
        chk("mem_we", bus.mem_we, m_we);
        chk("mem_addr", bus.mem_addr, m_addr);
        if (m_we) chk("mem_wdata", bus.mem_wdata, m_data);
      end
      chk("rd_ready", bus.dma_rd_ready, m_rdy);
      chk("rd_data", bus.dma_rd_data, m_rdata);
      chk("level", level, m_wq.size());
      chk("idle", idle, !m_act && m_pend.size() == 0 && m_wq.size() == 0);
      chk("err_rd", err_rd, m_erd);
      chk("err_wr", err_wr, m_ewr);
      if (bus.mem_req && bus.mem_gnt) begin
        log_we.push_back(bus.mem_we);
        log_addr.push_back(bus.mem_addr);
        log_data.push_back(bus.mem_wdata);
      end
      if (bus.dma_rd_ready) rdy_cnt++;
      if (int'(level) > peak) peak = int'(level);
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic clear_log();
    log_we.delete(); log_addr.delete(); log_data.delete();
    rdy_cnt = 0; peak = 0;
  endtask
  task automatic reset_dut();
    rst_n = 1'b0;
    bus.dma_rd_en = 0; bus.dma_rd_addr = '0; bus.dma_wr_en = 0; bus.dma_wr_addr = '0;
    bus.dma_wr_data = '0; bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic wait_idle(string name, int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = idle;
    end
    chk({name, "_drain"}, done, 1);
    tick();
  endtask
  task automatic prio(int nw, int ridx);
    reset_dut();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h1234_0000 + nw;
    for (int k = 0; k < nw; k++) begin
      bus.dma_wr_en = 1; bus.dma_wr_addr = 32'h500 + 4 * k; bus.dma_wr_data = k;
      tick();
    end
    bus.dma_wr_en = 0; bus.dma_rd_en = 1; bus.dma_rd_addr = 32'h300;
    tick();
    bus.dma_rd_en = 0;
    tick();
    clear_log();
    bus.mem_gnt = 1;
    wait_idle("t4", 100);
    chk("t4_count", log_we.size(), nw + 1);
    if (log_we.size() > ridx) begin
      chk("t4_rd_we", log_we[ridx], 0);
      chk("t4_rd_addr", log_addr[ridx], 32'h300);
    end
    if (log_we.size() > 0) chk("t4_first_wdata", log_data[0], 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int lat, got, seg_g, seg_w;
    logic [AW-1:0] seen_addr;
    reset_dut();
    @(negedge clk);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_ready", bus.dma_rd_ready, 0);
    chk("rst_level", level, 0);
    chk("rst_idle", idle, 1);
    tick();
    // 1: single read
    bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEADBEEF;
    bus.dma_rd_en = 1; bus.dma_rd_addr = 32'h100;
    tick();
    bus.dma_rd_en = 0;
    lat = 0; got = 0; seen_addr = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.mem_req) seen_addr = bus.mem_addr;
      if (bus.dma_rd_ready) begin if (got == 0) lat = i; got++; end
      tick();
    end
    chk("t1_latency", lat, 4);
    chk("t1_pulses", got, 1);
    chk("t1_addr", seen_addr, 32'h100);
    chk("t1_data", bus.dma_rd_data, 32'hDEADBEEF);
    chk("t1_idle", idle, 1);
    // 2: write burst with gnt held
    bus.mem_rvalid = 0;
    clear_log();
    for (int k = 0; k < 8; k++) begin
      bus.dma_wr_en = 1; bus.dma_wr_addr = 32'h200 + 4 * k; bus.dma_wr_data = k;
      tick();
    end
    bus.dma_wr_en = 0;
    wait_idle("t2", 60);
    chk("t2_count", log_we.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < log_we.size()) begin
        chk("t2_we", log_we[k], 1);
        chk("t2_addr", log_addr[k], 32'h200 + 4 * k);
        chk("t2_data", log_data[k], k);
      end
    chk("t2_peak_le8", peak <= 8, 1);
    chk("t2_err_wr", err_wr, 0);
    // 3: write overflow
    reset_dut();
    for (int k = 0; k < 9; k++) begin
      bus.dma_wr_en = 1; bus.dma_wr_addr = 32'h400 + 4 * k; bus.dma_wr_data = k;
      tick();
    end
    bus.dma_wr_en = 0;
    @(negedge clk);
    chk("t3_level", level, 8);
    chk("t3_err_wr", err_wr, 1);
    tick();
    clear_log();
    bus.mem_gnt = 1;
    wait_idle("t3", 60);
    chk("t3_count", log_we.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < log_data.size()) chk("t3_data", log_data[k], k);
    // 4: high-water priority
    prio(2, 1);
    prio(6, 1);
    prio(7, 2);
    // 5: read overflow
    reset_dut();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h55;
    bus.dma_rd_en = 1; bus.dma_rd_addr = 32'h10; tick();
    bus.dma_rd_addr = 32'h14; tick();
    bus.dma_rd_addr = 32'h18; tick();
    bus.dma_rd_en = 0;
    repeat (5) tick();
    clear_log();
    bus.mem_gnt = 1;
    wait_idle("t5", 60);
    chk("t5_count", log_we.size(), 2);
    if (log_addr.size() >= 2) begin
      chk("t5_addr0", log_addr[0], 32'h10);
      chk("t5_addr1", log_addr[1], 32'h14);
    end
    chk("t5_pulses", rdy_cnt, 2);
    chk("t5_err_rd", err_rd, 1);
    // 6: reset during RD_WAIT, late rvalid ignored
    bus.mem_rvalid = 0;
    bus.dma_rd_en = 1; bus.dma_rd_addr = 32'h40; tick();
    bus.dma_rd_en = 0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req", bus.mem_req, 0);
    chk("t6_we", bus.mem_we, 0);
    chk("t6_ready", bus.dma_rd_ready, 0);
    chk("t6_rd_data", bus.dma_rd_data, 0);
    chk("t6_level", level, 0);
    chk("t6_idle", idle, 1);
    chk("t6_err_rd", err_rd, 0);
    chk("t6_err_wr", err_wr, 0);
    tick();
    rst_n = 1'b1;
    clear_log();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hBAD;
    repeat (4) tick();
    chk("t6_no_ready", rdy_cnt, 0);
    chk("t6_no_req", log_we.size(), 0);
    bus.mem_rvalid = 0;
    // random traffic against the model
    reset_dut();
    seg_g = 50; seg_w = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        seg_g = (i / 100) % 3 == 0 ? 5 : ((i / 100) % 3 == 1 ? 40 : 90);
        seg_w = $urandom_range(10, 90);
      end
      bus.dma_rd_en   = $urandom_range(0, 99) < 25;
      bus.dma_rd_addr = $urandom & 32'hFFFF_FFFC;
      bus.dma_wr_en   = $urandom_range(0, 99) < seg_w;
      bus.dma_wr_addr = $urandom & 32'hFFFF_FFFC;
      bus.dma_wr_data = $urandom;
      bus.mem_gnt     = $urandom_range(0, 99) < seg_g;
      bus.mem_rvalid  = $urandom_range(0, 1);
      bus.mem_rdata   = $urandom;
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else tick();
    end
    bus.dma_rd_en = 0; bus.dma_wr_en = 0; bus.mem_gnt = 1; bus.mem_rvalid = 1;
    wait_idle("rand", 200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
